// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD bus arbiter.
//   state_e      - transfer FSM states
//   *_CYC_DEF    - default timing in clk cycles
//   LCD_CMD_*    - HD44780-style command codes that need the long hold
//   cyc_to_cnt() - converts a cycle count to a down-counter reload value
package lcd_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StPulse,
      StHold,
      StDone
   } state_e;

   localparam int unsigned CNT_W        = 17;
   localparam int unsigned E_HIGH_CYC_DEF = 2500;
   localparam int unsigned GAP_CYC_DEF    = 2500;
   localparam int unsigned LONG_CYC_DEF   = 100000;

   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

   // The counter runs down to zero, so a dwell of N cycles reloads N-1.
   function automatic logic [CNT_W-1:0] cyc_to_cnt(input int unsigned cyc);
      return CNT_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// lcd_rr_arb2: two-way round-robin selector (purely combinational).
//   req_i   [1:0] - request vector
//   ptr_i         - requester preferred when both request
//   valid_o       - at least one request present
//   grant_o       - index of the selected requester
module lcd_rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic       valid_o,
   output logic       grant_o
);

   always_comb begin
      valid_o = |req_i;
      // Single request wins outright; the pointer only breaks ties.
      grant_o = (req_i == 2'b11) ? ptr_i : req_i[1];
   end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one character-LCD bus between two requesters.
// A granted transfer runs SETUP (1 cycle) -> PULSE (lcd_e high) -> HOLD (lcd_e low,
// short or long) -> DONE (1-cycle ack) and returns to IDLE.
//   clk, reset           - clock, synchronous active-high reset
//   req, req_rs, req_long - per-requester request / register select / long flag
//   req_data0, req_data1 - per-requester byte
//   busyF                - LCD busy flag, gates only the start of a transfer
//   lcd_data, lcd_rs, lcd_rw, lcd_e - LCD bus
//   ack                  - one-cycle completion pulse per requester
//   grant_id, busy       - current owner, transfer in progress
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int unsigned E_HIGH_CYC = E_HIGH_CYC_DEF,
   parameter int unsigned GAP_CYC    = GAP_CYC_DEF,
   parameter int unsigned LONG_CYC   = LONG_CYC_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] req_rs,
   input  logic [7:0] req_data0,
   input  logic [7:0] req_data1,
   input  logic [1:0] req_long,
   input  logic       busyF,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [1:0] ack,
   output logic       grant_id,
   output logic       busy
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             grant_q, grant_d;
   logic             ptr_q, ptr_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             long_q, long_d;

   logic arb_valid;
   logic arb_grant;

   lcd_rr_arb2 u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .valid_o (arb_valid),
      .grant_o (arb_grant)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      rs_d    = rs_q;
      data_d  = data_q;
      long_d  = long_q;
      case (state_q)
         StIdle: begin
            // busyF is only looked at here; once latched, the transfer is committed.
            if (arb_valid && !busyF) begin
               state_d = StSetup;
               cnt_d   = '0;
               grant_d = arb_grant;
               rs_d    = req_rs[arb_grant];
               data_d  = arb_grant ? req_data1 : req_data0;
               long_d  = req_long[arb_grant];
            end
         end
         StSetup: begin
            state_d = StPulse;
            cnt_d   = cyc_to_cnt(E_HIGH_CYC);
         end
         StPulse: begin
            if (cnt_q == '0) begin
               state_d = StHold;
               cnt_d   = long_q ? cyc_to_cnt(LONG_CYC) : cyc_to_cnt(GAP_CYC);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               state_d = StDone;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            cnt_d   = '0;
            ptr_d   = ~grant_q;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         grant_q <= 1'b0;
         ptr_q   <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= '0;
         long_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         long_q  <= long_d;
      end
   end

   // All outputs decode straight from registers, so they change only on clk edges.
   always_comb begin
      lcd_e    = (state_q == StPulse);
      busy     = (state_q != StIdle);
      lcd_rw   = 1'b0;
      lcd_rs   = rs_q;
      lcd_data = data_q;
      grant_id = grant_q;
      ack      = 2'b00;
      if (state_q == StDone) begin
         ack = grant_q ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed plus randomized checks of lcd_bus_arbiter with
// scaled timing (E_HIGH_CYC=4, GAP_CYC=4, LONG_CYC=20).
module tb_lcd_bus_arbiter;
   import lcd_pkg::*;

   localparam int unsigned EH = 4;
   localparam int unsigned GP = 4;
   localparam int unsigned LG = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req, req_rs, req_long;
   logic [7:0] req_data0, req_data1;
   logic       busyF;
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_rw, lcd_e, grant_id, busy;
   logic [1:0] ack;

   int n_cmp = 0;
   int n_bad = 0;
   int pref;  // model: requester favoured on a tie

   lcd_bus_arbiter #(
      .E_HIGH_CYC (EH),
      .GAP_CYC    (GP),
      .LONG_CYC   (LG)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_rs    (req_rs),
      .req_data0 (req_data0),
      .req_data1 (req_data1),
      .req_long  (req_long),
      .busyF     (busyF),
      .lcd_data  (lcd_data),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_e     (lcd_e),
      .ack       (ack),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(input logic [1:0] r);
      if (r == 2'b11) return pref;
      return r[1] ? 1 : 0;
   endfunction

   function automatic logic [14:0] vec();
      return {busy, lcd_e, lcd_rw, lcd_rs, lcd_data, ack, grant_id};
   endfunction

   // Runs one transfer from an IDLE negedge, checking every cycle against the
   // expected SETUP/PULSE/HOLD/DONE shape. Inputs are scrambled mid-transfer.
   task automatic xfer(input string tag, input bit keep, input int drop_at,
                       input int max_wait, output int waited);
      int         w, hold;
      logic       wb, ers, el;
      logic [7:0] ed;
      logic [1:0] s_rs, s_long;
      logic [7:0] s_d0, s_d1;
      logic       s_bf;
      w    = winner(req);
      wb   = (w == 1);
      ers  = req_rs[wb];
      ed   = wb ? req_data1 : req_data0;
      el   = req_long[wb];
      hold = el ? int'(LG) : int'(GP);
      s_rs = req_rs; s_long = req_long; s_d0 = req_data0; s_d1 = req_data1; s_bf = busyF;
      waited = 0;
      while (busy !== 1'b1 && waited < max_wait) begin
         @(negedge clk);
         waited++;
      end
      if (busy !== 1'b1) begin
         check({tag, "_start"}, {31'd0, busy}, 32'd1);
         return;
      end
      check({tag, "_setup"}, vec(), {1'b1, 1'b0, 1'b0, ers, ed, 2'b00, wb});
      for (int i = 0; i < int'(EH) + hold; i++) begin
         req_rs    = 2'($urandom);
         req_data0 = 8'($urandom);
         req_data1 = 8'($urandom);
         req_long  = 2'($urandom);
         busyF     = 1'($urandom);
         if (i == drop_at) req[wb] = 1'b0;
         @(negedge clk);
         if (i < int'(EH))
            check({tag, "_pulse"}, vec(), {1'b1, 1'b1, 1'b0, ers, ed, 2'b00, wb});
         else
            check({tag, "_hold"}, vec(), {1'b1, 1'b0, 1'b0, ers, ed, 2'b00, wb});
      end
      req_rs = s_rs; req_long = s_long; req_data0 = s_d0; req_data1 = s_d1; busyF = s_bf;
      if (!keep) req[wb] = 1'b0;
      @(negedge clk);
      check({tag, "_done"}, vec(), {1'b1, 1'b0, 1'b0, ers, ed, (wb ? 2'b10 : 2'b01), wb});
      pref = 1 - w;
      @(negedge clk);
      check({tag, "_idle"}, {busy, lcd_e, ack}, 32'd0);
   endtask

   initial begin
      int wt;
      int nb;
      reset = 1'b1; req = '0; req_rs = '0; req_long = '0;
      req_data0 = '0; req_data1 = '0; busyF = 1'b0; pref = 0;
      repeat (3) @(negedge clk);
      check("reset_vec", vec(), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_idle", vec(), 32'd0);

      // Single short data write.
      req = 2'b01; req_rs = 2'b01; req_data0 = 8'h31;
      xfer("short", 1'b0, -1, 4, wt);
      check("short_wait", wt, 32'd1);

      // Long clear command.
      req_rs = 2'b00; req_data0 = LCD_CMD_CLEAR; req_long = 2'b01; req = 2'b01;
      xfer("clear", 1'b0, -1, 4, wt);
      req_long = 2'b00;

      // Contention from a fresh reset: both held, back-to-back alternation.
      reset = 1'b1; @(negedge clk); reset = 1'b0; pref = 0;
      req = 2'b11; req_rs = 2'b10; req_data0 = 8'hA0; req_data1 = 8'hB1;
      for (int k = 0; k < 4; k++) begin
         xfer("contend", 1'b1, -1, 4, wt);
         check("contend_b2b", wt, 32'd1);
      end
      req = 2'b00;

      // busyF blocks the start, release starts on the next edge.
      busyF = 1'b1; req = 2'b01; req_rs = 2'b00; req_data0 = LCD_CMD_HOME;
      repeat (6) begin
         @(negedge clk);
         check("busyf_block", {busy, lcd_e, ack}, 32'd0);
      end
      busyF = 1'b0;
      xfer("busyf", 1'b0, -1, 4, wt);
      check("busyf_wait", wt, 32'd1);

      // Reset during PULSE aborts without ack; requester 1 is then served.
      req = 2'b10; req_rs = 2'b10; req_data1 = 8'h5A;
      @(negedge clk);
      @(negedge clk);
      check("abort_in_pulse", {31'd0, lcd_e}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_vec", vec(), 32'd0);
      req_data1 = 8'h6B;
      reset = 1'b0; pref = 0;
      xfer("after_abort", 1'b0, -1, 4, wt);

      // Withdrawal during HOLD still gets its ack.
      req = 2'b01; req_rs = 2'b01; req_data0 = 8'h77;
      xfer("withdraw", 1'b0, int'(EH) + 1, 4, wt);

      // Randomized traffic against the model.
      for (int n = 0; n < 25; n++) begin
         req       = 2'($urandom_range(1, 3));
         req_rs    = 2'($urandom);
         req_data0 = 8'($urandom);
         req_data1 = 8'($urandom);
         req_long  = 2'($urandom & $urandom);
         nb = $urandom_range(0, 2);
         if (nb > 0) begin
            busyF = 1'b1;
            repeat (nb) begin
               @(negedge clk);
               check("rand_busyf", {busy, lcd_e, ack}, 32'd0);
            end
            busyF = 1'b0;
         end
         xfer("rand", 1'b0, -1, 4, wt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter E_HIGH_CYC, default 2500, clk cycles lcd_e is held high per transfer.
REQ-002 Parameter GAP_CYC, default 2500, clk cycles lcd_e is held low after a short transfer.
REQ-003 Parameter LONG_CYC, default 100000, clk cycles lcd_e is held low after a long transfer (clear/home).
REQ-004 clk  in  1  system clock; the design has one clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  2  per-requester transfer request, level, held until ack.
REQ-007 req_rs  in  2  per-requester register select (0 command, 1 data).
REQ-008 req_data0 / req_data1  in  8 each  per-requester byte.
REQ-009 req_long  in  2  per-requester long-execution flag.
REQ-010 busyF  in  1  LCD busy flag; high blocks the start of a new transfer.
REQ-011 lcd_data  out  8  LCD data bus.
REQ-012 lcd_rs, lcd_rw, lcd_e  out  1 each  LCD control lines; lcd_rw is tied to 0.
REQ-013 ack  out  2  one-cycle completion pulse per requester.
REQ-014 grant_id  out  1  index of the requester owning the bus, valid while busy is high.
REQ-015 busy  out  1  high from SETUP through DONE.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, PULSE, HOLD and DONE.
REQ-017 IDLE: if any req bit is high and busyF=0, the block SHALL latch the winner's rs, data and long into internal registers, set grant_id, and go to SETUP on the next edge.
REQ-018 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; the pointer after reset SHALL favour requester 0.
REQ-019 SETUP SHALL last 1 cycle, with lcd_rs and lcd_data driven from the latched values and lcd_e=0.
REQ-020 PULSE SHALL hold lcd_e=1 for exactly E_HIGH_CYC cycles; rs and data SHALL stay stable.
REQ-021 HOLD SHALL hold lcd_e=0 for GAP_CYC cycles, or LONG_CYC cycles if the latched long flag is 1; rs and data SHALL stay stable.
REQ-022 DONE SHALL last 1 cycle, assert ack[grant_id] for that cycle only, update the round-robin pointer, and return to IDLE.
REQ-023 Request changes after latching SHALL NOT affect the transfer in progress.
REQ-024 A requester dropping req mid-transfer SHALL still receive its ack; the transfer SHALL complete.
REQ-025 busyF SHALL be sampled only in IDLE; busyF rising mid-transfer SHALL be ignored.
REQ-026 Back-to-back transfers are allowed: a request present in the cycle after DONE SHALL win in IDLE; minimum IDLE dwell is 1 cycle.
REQ-027 The counter SHALL be 17 bits wide, saturation-free, reloaded on every state entry; LONG_CYC up to 131071 SHALL be supported.
REQ-028 Total transfer latency from IDLE grant to ack SHALL be 1 + E_HIGH_CYC + hold + 1 cycles.

Reset
REQ-029 While reset=1: state=IDLE, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0, ack=0, busy=0, grant_id=0, RR pointer favours requester 0, counter=0.
REQ-030 Reset asserted mid-PULSE SHALL drop lcd_e on the next edge, and no ack SHALL be issued for the aborted transfer.

Structure
REQ-031 A shared package lcd_pkg SHALL hold the state enum type, the default timing constants, and the LCD command codes (CLEAR=8'h01, HOME=8'h02).
REQ-032 One sub-module, lcd_rr_arb2, SHALL implement the 2-way round-robin selection (req, pointer in; grant out); all else is in lcd_bus_arbiter.

Verification (scaled parameters E_HIGH_CYC=4, GAP_CYC=4, LONG_CYC=20)
REQ-033 Single short: req=01, req_rs=1, data0=8'h31 -> lcd_e high 4 cycles with data 8'h31 and rs=1, ack=01 exactly 10 cycles after grant.
REQ-034 Long clear: req0 with rs=0, data=8'h01, long=1 -> lcd_e high 4 cycles, then low 20 cycles, then ack=01.
REQ-035 Contention: req=11 held -> grants alternate 0,1,0,1; each ack is a single pulse; no overlap of lcd_e high periods.
REQ-036 busyF: busyF=1 with req=01 -> lcd_e stays 0 and busy=0; busyF falls -> SETUP on the next edge.
REQ-037 Reset during PULSE -> lcd_e=0 and busy=0 after one edge, no ack; a fresh req1 after release is served normally.
REQ-038 Withdrawal: req0 drops during HOLD -> ack[0] is still pulsed once, and lcd_data stays at the latched value until DONE.
